mem_bus_master: RTL

- CPU-side initiator for the MU0 memory bus. It is the requesting end of the memRq / readNotWrite / addr / data interface that the memory block responds to.
- Accepts one read or write request at a time from the core over a valid/ready handshake.
- Sequences the bus strobes with registered outputs: memRq is held for a programmable access window, then addr/data are held one extra cycle.
- Returns a one-cycle response pulse, carrying read data for reads.

---
 rtl/mem_bus_master.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side initiator for the MU0 memory bus.
//
// Takes one read or write request at a time from the core over a valid/ready handshake.
// It raises memRq for WAIT_CYCLES+1 cycles, then holds addr/readNotWrite/memWData for one
// more cycle. It then returns a one-cycle response pulse, which carries the read data
// for reads.
//
// Ports:
//   clk, reset        - system clock; asynchronous active-high reset
//   reqValid/reqReady - request handshake (reqReady is low while in reset)
//   reqRead           - 1 = read, 0 = write (sampled at acceptance)
//   reqAddr/reqWData  - request address / write data (sampled at acceptance)
//   rspValid          - one-cycle completion pulse
//   rspRead/rspData   - kind of completed transaction / captured read data
//   memRq             - bus request strobe
//   readNotWrite      - bus direction (1 = read)
//   addr/memWData     - bus address / write data to memory
//   memRData          - read data from memory
module mem_bus_master #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqRead,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [DATA_WIDTH-1:0] reqWData,
  output logic                  rspValid,
  output logic                  rspRead,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic                  memRq,
  output logic                  readNotWrite,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData
);

  // The wait counter is 4 bits wide, so larger values cannot be represented.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gen_wait_cycles_check
    $fatal(1, "mem_bus_master: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StHold, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  mem_rq_q, mem_rq_d;
  logic                  rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_read_q, rsp_read_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_rq_q    <= 1'b0;
      rnw_q       <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_rq_q    <= mem_rq_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_read_q  <= rsp_read_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_rq_d    = mem_rq_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_read_d  = rsp_read_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      StIdle: begin
        // The clocked branch only runs with reset low, so reqReady is implied here.
        if (reqValid) begin
          rnw_d    = reqRead;
          addr_d   = reqAddr;
          wdata_d  = reqWData;
          mem_rq_d = 1'b1;
          cnt_d    = WaitInit;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final strobe cycle: the only point where memory data is valid for a read.
          if (rnw_q) begin
            rsp_data_d = memRData;
          end
          mem_rq_d = 1'b0;
          state_d  = StHold;
        end
      end
      StHold: begin
        // Address and write data stay put one cycle past memRq for the write latch.
        rsp_valid_d = 1'b1;
        rsp_read_d  = rnw_q;
        rnw_d       = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign reqReady     = (state_q == StIdle) && !reset;
  assign rspValid     = rsp_valid_q;
  assign rspRead      = rsp_read_q;
  assign rspData      = rsp_data_q;
  assign memRq        = mem_rq_q;
  assign readNotWrite = rnw_q;
  assign addr         = addr_q;
  assign memWData     = wdata_q;

endmodule
